// File: rtl/pwm_pkg.sv
// Shared types for the PWM dead-time generator: channel FSM states and default widths.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        ACTIVE = 2'd2
    } dtg_state_t;

    localparam int DT_W_DEF = 8;

endpackage

// File: rtl/pwm_dtg_chan.sv
// One dead-time channel: IDLE/DELAY/ACTIVE FSM with a down-counter that holds off each rising edge.
module pwm_dtg_chan
    import pwm_pkg::*;
#(
    parameter int DT_W = DT_W_DEF
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            ref_i,
    input  logic [DT_W-1:0] dt_i,
    input  logic            ok_i,
    input  logic            en_i,
    output logic            act_o,
    output logic            entering_o,
    output logic            busy_o
);

    dtg_state_t      state_q;
    logic [DT_W-1:0] cnt_q;

    // Exported so the partner channel can lose a simultaneous race into ACTIVE.
    assign entering_o = en_i && ref_i && ok_i &&
                        (((state_q == IDLE) && (dt_i == '0)) ||
                         ((state_q == DELAY) && (cnt_q == '0)));

    assign act_o  = (state_q == ACTIVE);
    assign busy_o = (state_q == DELAY);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else if (!en_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ref_i) begin
                        if (entering_o) begin
                            state_q <= ACTIVE;
                        end else begin
                            state_q <= DELAY;
                            cnt_q   <= (dt_i == '0) ? '0 : dt_i - DT_W'(1);
                        end
                    end
                end
                DELAY: begin
                    if (!ref_i) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - DT_W'(1);
                    end else if (entering_o) begin
                        state_q <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (!ref_i) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pwm_dtg.sv
// Dead-time generator and output stage for one PWM channel pair.
// Optional break/fault handling is compiled in with `define PWM_DTG_BREAK_EN.
module pwm_dtg
    import pwm_pkg::*;
#(
    parameter int DT_W = DT_W_DEF
) (
    input  logic            clk_psc_i,
    input  logic            rst_n_i,
`ifdef PWM_DTG_BREAK_EN
    input  logic            break_i,
    input  logic            brk_clr_i,
    output logic            brk_flag_o,
`endif
    input  logic            oc_a_ref_i,
    input  logic            oc_b_ref_i,
    input  logic [DT_W-1:0] dt_cnt_i,
    input  logic            dt_update_i,
    input  logic            interlock_en_i,
    input  logic            out_en_i,
    input  logic            pol_a_i,
    input  logic            pol_b_i,
    input  logic            idle_a_i,
    input  logic            idle_b_i,
    output logic            pwm_a_o,
    output logic            pwm_b_o,
    output logic            dt_busy_o
);

    logic [DT_W-1:0] dtShd_q;
    logic [DT_W-1:0] dtPend_q;
    logic            pendValid_q;
    logic            pinA_q;
    logic            pinB_q;
    logic            runEn;
    logic            actA;
    logic            actB;
    logic            enteringA;
    logic            enteringB;
    logic            busyA;
    logic            busyB;
    logic            okA;
    logic            okB;

`ifdef PWM_DTG_BREAK_EN
    logic brkFlag_q;

    // A fault outranks a clear request arriving on the same edge.
    always_ff @(posedge clk_psc_i) begin
        if (!rst_n_i) begin
            brkFlag_q <= 1'b0;
        end else if (break_i) begin
            brkFlag_q <= 1'b1;
        end else if (brk_clr_i) begin
            brkFlag_q <= 1'b0;
        end
    end

    assign brk_flag_o = brkFlag_q;
    assign runEn      = out_en_i && !break_i && !brkFlag_q;
`else
    assign runEn = out_en_i;
`endif

    // Channel A wins a simultaneous entry, so B also yields to A's entering strobe.
    assign okA = !interlock_en_i || !actB;
    assign okB = !interlock_en_i || !(actA || enteringA);

    pwm_dtg_chan #(.DT_W(DT_W)) u_chan_a (
        .clk_i      (clk_psc_i),
        .rst_n_i    (rst_n_i),
        .ref_i      (oc_a_ref_i),
        .dt_i       (dtShd_q),
        .ok_i       (okA),
        .en_i       (runEn),
        .act_o      (actA),
        .entering_o (enteringA),
        .busy_o     (busyA)
    );

    pwm_dtg_chan #(.DT_W(DT_W)) u_chan_b (
        .clk_i      (clk_psc_i),
        .rst_n_i    (rst_n_i),
        .ref_i      (oc_b_ref_i),
        .dt_i       (dtShd_q),
        .ok_i       (okB),
        .en_i       (runEn),
        .act_o      (actB),
        .entering_o (enteringB),
        .busy_o     (busyB)
    );

    assign dt_busy_o = busyA || busyB;

    // Shadow only changes while no channel is counting, so an in-flight delay keeps its length.
    always_ff @(posedge clk_psc_i) begin
        if (!rst_n_i) begin
            dtShd_q     <= '0;
            dtPend_q    <= '0;
            pendValid_q <= 1'b0;
        end else if (dt_update_i) begin
            if (!dt_busy_o) begin
                dtShd_q     <= dt_cnt_i;
                pendValid_q <= 1'b0;
            end else begin
                dtPend_q    <= dt_cnt_i;
                pendValid_q <= 1'b1;
            end
        end else if (pendValid_q && !dt_busy_o) begin
            dtShd_q     <= dtPend_q;
            pendValid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_psc_i) begin
        if (!rst_n_i) begin
            pinA_q <= 1'b0;
            pinB_q <= 1'b0;
        end else begin
            pinA_q <= runEn ? (actA ^ pol_a_i) : idle_a_i;
            pinB_q <= runEn ? (actB ^ pol_b_i) : idle_b_i;
        end
    end

    assign pwm_a_o = pinA_q;
    assign pwm_b_o = pinB_q;

    // B's entering strobe is only needed by a wider interlock scheme; keep it observed.
    logic unusedEnteringB;
    assign unusedEnteringB = enteringB;

endmodule
